// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one imem request at a time
// and presents {pc, instr, exception} to the fetch/decode register.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [63:0] pc_o,
  output logic [31:0] instr_o,
  output logic [15:0] exception_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [15:0] exc;
    logic        vld;
  } fd_t;

  localparam logic [15:0] EXC_MISALIGN = 16'h0001;
  localparam logic [15:0] EXC_FAULT    = 16'h0002;

  state_t      state, state_nx;
  logic [63:0] pc, pc_nx;
  fd_t         out_q, out_nx;
  logic        misaligned;

  assign misaligned = (pc[1:0] != 2'b00);
  // Gated by rst so no request leaks out while the whole pipe is resetting.
  assign imem_req   = !rst && (state == S_REQ) && !misaligned && !redirect_valid;
  assign imem_addr  = pc;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    out_nx   = out_q;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_nx = redirect_pc;
        end else if (misaligned) begin
          out_nx   = '{pc: pc, instr: 32'h0, exc: EXC_MISALIGN, vld: 1'b1};
          state_nx = S_HOLD;
        end else if (imem_ready) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nx    = redirect_pc;
          // Without the response in hand we must still swallow it later.
          state_nx = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          out_nx.pc    = pc;
          out_nx.vld   = 1'b1;
          out_nx.instr = imem_err ? 32'h0 : imem_rdata;
          out_nx.exc   = imem_err ? EXC_FAULT : 16'h0;
          state_nx     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          out_nx.vld = 1'b0;
          pc_nx      = redirect_pc;
          state_nx   = S_REQ;
        end else if (!stall_i) begin
          out_nx.vld = 1'b0;
          pc_nx      = pc + 64'd4;
          state_nx   = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_nx = redirect_pc;
        if (imem_rvalid)    state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      out_q <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      out_q <= out_nx;
    end
  end

  assign pc_o        = out_q.pc;
  assign instr_o     = out_q.instr;
  assign exception_o = out_q.exc;
  assign valid_o     = out_q.vld;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed walk through the fetch scenarios, then random
// traffic checked against an architectural-PC model and an address-keyed memory.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready, imem_rvalid, imem_err;
  logic [31:0] imem_rdata;
  logic [63:0] pc_o;
  logic [31:0] instr_o;
  logic [15:0] exception_o;
  logic        valid_o;

  ifetch_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .pc_o(pc_o), .instr_o(instr_o), .exception_o(exception_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Instruction memory content and faults are a pure function of the address.
  function automatic logic [31:0] mdata(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0000_0013;
    if (a == 64'h8000_0004) return 32'hDEAD_BEEF;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  function automatic logic merr(input logic [63:0] a);
    return (a == 64'h8000_0008) || (a[31:28] == 4'h9 && a[4:2] == 3'd5);
  endfunction

  // Reference state: architectural fetch PC plus a single-slot memory.
  logic [63:0] mpc;
  logic        mem_busy;
  int          mem_cnt;
  logic [63:0] mem_a;
  int          lat = 1;
  logic        req_seen;
  logic [63:0] addr_seen;
  int          npres = 0;
  logic        saw_dead = 1'b0;

  task automatic tick(input logic st, input logic rv, input logic [63:0] rp, input logic rdy);
    logic        pv;
    logic [63:0] ppc;
    logic [31:0] pin, ein;
    logic [15:0] pex, eex;
    stall_i = st; redirect_valid = rv; redirect_pc = rp; imem_ready = rdy;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = mdata(mem_a);
    imem_err    = merr(mem_a);
    #1;
    req_seen = imem_req; addr_seen = imem_addr;
    pv = valid_o; ppc = pc_o; pin = instr_o; pex = exception_o;
    if (imem_req) begin
      chk("req_addr", imem_addr, mpc);
      chk("req_outstanding", {63'h0, mem_busy}, 64'h0);
    end
    if (rv) chk("req_during_redirect", {63'h0, imem_req}, 64'h0);
    if (mpc[1:0] != 2'b00) chk("req_misaligned", {63'h0, imem_req}, 64'h0);
    if (mem_busy) chk("req_while_busy", {63'h0, imem_req}, 64'h0);
    @(posedge clk);
    #1;
    if (rv) mpc = rp;
    else if (pv && !st) mpc = mpc + 64'd4;
    if (imem_rvalid) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (req_seen && rdy) begin
      mem_busy = 1'b1; mem_cnt = lat - 1; mem_a = addr_seen;
    end
    if (pv && st && !rv) begin
      chk("stall_valid", {63'h0, valid_o}, 64'h1);
      chk("stall_pc", pc_o, ppc);
      chk("stall_instr", {32'h0, instr_o}, {32'h0, pin});
      chk("stall_exc", {48'h0, exception_o}, {48'h0, pex});
    end else if (pv) begin
      chk("valid_fall", {63'h0, valid_o}, 64'h0);
    end else if (valid_o) begin
      npres++;
      eex = (mpc[1:0] != 2'b00) ? 16'h0001 : (merr(mpc) ? 16'h0002 : 16'h0000);
      ein = (eex != 16'h0) ? 32'h0 : mdata(mpc);
      chk("pres_pc", pc_o, mpc);
      chk("pres_instr", {32'h0, instr_o}, {32'h0, ein});
      chk("pres_exc", {48'h0, exception_o}, {48'h0, eex});
    end
    if (valid_o && instr_o == 32'hDEAD_BEEF) saw_dead = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_pc();
    int r = $urandom % 8;
    logic [27:0] lo = 28'($urandom);
    if (r == 0) return 64'hFFFF_FFFF_FFFF_FFF8;
    if (r == 1) return {32'h0, 4'h8, lo[27:2], 2'b01 + 2'($urandom % 3)};
    return {32'h0, 4'h9, lo[27:2], 2'b00};
  endfunction

  initial begin
    rst = 1'b1; stall_i = 0; redirect_valid = 0; redirect_pc = '0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0; imem_err = 0;
    mem_busy = 0; mem_cnt = 0; mem_a = '0; mpc = 64'h8000_0000;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_valid", {63'h0, valid_o}, 64'h0);
    chk("rst_pc", pc_o, 64'h0);
    chk("rst_instr", {32'h0, instr_o}, 64'h0);
    chk("rst_exc", {48'h0, exception_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait fetch from reset PC
    lat = 1;
    tick(0, 0, '0, 1);
    chk("first_req", {63'h0, req_seen}, 64'h1);
    chk("first_addr", addr_seen, 64'h8000_0000);
    tick(0, 0, '0, 0);
    chk("first_valid", {63'h0, valid_o}, 64'h1);
    chk("first_pc", pc_o, 64'h8000_0000);
    chk("first_instr", {32'h0, instr_o}, 64'h13);
    chk("first_exc", {48'h0, exception_o}, 64'h0);

    // Five stalled cycles in HOLD, then release
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, '0, 1);
      chk("stall_hold_v", {63'h0, valid_o}, 64'h1);
      chk("stall_hold_pc", pc_o, 64'h8000_0000);
    end
    tick(0, 0, '0, 0);
    chk("release_valid", {63'h0, valid_o}, 64'h0);

    // Redirect while waiting; orphaned DEADBEEF must be swallowed
    lat = 4;
    tick(0, 0, '0, 1);
    chk("seq_addr", addr_seen, 64'h8000_0004);
    tick(0, 1, 64'h8000_0100, 0);
    tick(0, 0, '0, 1);
    chk("drop_noreq", {63'h0, req_seen}, 64'h0);
    tick(0, 0, '0, 1);
    tick(0, 0, '0, 1);
    lat = 1;
    tick(0, 0, '0, 1);
    chk("redir_addr", addr_seen, 64'h8000_0100);
    chk("redir_req", {63'h0, req_seen}, 64'h1);
    tick(0, 0, '0, 0);
    chk("redir_valid", {63'h0, valid_o}, 64'h1);

    // Redirect in HOLD under stall to a misaligned PC
    tick(1, 1, 64'h8000_0102, 1);
    chk("hold_redir_clear", {63'h0, valid_o}, 64'h0);
    tick(0, 0, '0, 1);
    chk("mis_noreq", {63'h0, req_seen}, 64'h0);
    chk("mis_valid", {63'h0, valid_o}, 64'h1);
    chk("mis_pc", pc_o, 64'h8000_0102);
    chk("mis_exc", {48'h0, exception_o}, 64'h1);
    chk("mis_instr", {32'h0, instr_o}, 64'h0);

    // Access fault at 0x8000_0008
    tick(0, 1, 64'h8000_0008, 0);
    tick(0, 0, '0, 1);
    tick(0, 0, '0, 0);
    chk("fault_pc", pc_o, 64'h8000_0008);
    chk("fault_exc", {48'h0, exception_o}, 64'h2);
    chk("fault_instr", {32'h0, instr_o}, 64'h0);
    tick(0, 0, '0, 0);

    // Redirect coincident with the response: straight back to REQ
    tick(0, 0, '0, 1);
    tick(0, 1, 64'h8000_0200, 0);
    chk("coinc_novalid", {63'h0, valid_o}, 64'h0);
    tick(0, 0, '0, 1);
    chk("coinc_req", {63'h0, req_seen}, 64'h1);
    chk("coinc_addr", addr_seen, 64'h8000_0200);
    chk("no_deadbeef", {63'h0, saw_dead}, 64'h0);

    // Random traffic
    npres = 0;
    for (int i = 0; i < 3000; i++) begin
      lat = int'($urandom_range(1, 4));
      tick(($urandom % 3) == 0, ($urandom % 12) == 0, rand_pc(), ($urandom % 2) == 0);
    end
    chk("progress", {63'h0, npres >= 100}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage: the producer side of the fetch→decode pipeline register.
- Holds the architectural fetch PC and issues one instruction-memory request at a time over a req/ready–rvalid interface.
- Presents {pc, instr, exception} with a valid flag to the fetch/decode register, which captures them when valid_o=1 and stall_i=0.
- Handles back-pressure, redirects (branch/trap), misaligned-PC and access-fault exceptions.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  downstream not accepting; complement of the fetch/decode register enable.
- redirect_valid  in  1  redirect request (branch mispredict/trap); highest priority.
- redirect_pc  in  64  new fetch PC, sampled when redirect_valid=1.
- imem_req  out  1  request valid.
- imem_addr  out  64  request address; equals current PC.
- imem_ready  in  1  memory accepts the request this cycle (req&ready = handshake).
- imem_rvalid  in  1  response valid; exactly one per accepted request, arriving ≥1 cycle after acceptance.
- imem_rdata  in  32  instruction word.
- imem_err  in  1  access fault; qualified by imem_rvalid.
- pc_o  out  64  PC of the presented instruction.
- instr_o  out  32  instruction word; 0 when an exception is flagged.
- exception_o  out  16  one-hot by mcause code: bit0 = misaligned fetch, bit1 = access fault; all other bits 0.
- valid_o  out  1  pc_o/instr_o/exception_o are meaningful.

Behaviour:
- Reset: pc←RESET_PC; state←REQ; imem_req=0 during the reset cycle; pc_o=0, instr_o=0, exception_o=0, valid_o=0. Memory shares rst, so no stale responses arrive after reset.
- Registers: pc, state, output registers. imem_req/imem_addr are combinational from state/pc.
- REQ:
  - imem_req = (pc[1:0]==0) & !redirect_valid.
  - If redirect_valid: pc←redirect_pc, stay REQ.
  - Else if pc[1:0]≠0: pc_o←pc, instr_o←0, exception_o←16'h0001, valid_o←1, →HOLD. No memory request is issued.
  - Else if imem_ready: →WAIT.
- WAIT:
  - imem_req=0.
  - redirect_valid (with or without imem_rvalid): pc←redirect_pc. If imem_rvalid, discard it and →REQ; else →DROP.
  - Else if imem_rvalid: pc_o←pc, valid_o←1, →HOLD.
    - If imem_err: instr_o←0, exception_o←16'h0002.
    - Else: instr_o←imem_rdata, exception_o←0.
- HOLD:
  - Outputs stable while stall_i=1.
  - redirect_valid: valid_o←0, pc←redirect_pc, →REQ.
  - Else if !stall_i: transfer occurs this cycle; valid_o←0, pc←pc+4 (64-bit, wraps modulo 2^64), →REQ.
- DROP:
  - imem_req=0.
  - Waits for the orphaned response.
  - redirect_valid updates pc, stays DROP.
  - imem_rvalid discards data; →REQ. If redirect_valid is also high that cycle, pc←redirect_pc as well.
- Priority: rst > redirect_valid > exception/response > stall.
- valid_o is never 1 in REQ, WAIT or DROP.
- Latency: zero-wait memory (ready in REQ, rvalid the next cycle) gives valid_o 2 cycles after entering REQ. Throughput is 1 instruction per 3 cycles without stall.
- At most one outstanding request at any time.

Test Plan:
- Reset, then zero-wait memory returning 32'h0000_0013 → imem_addr=0x8000_0000; valid_o=1 with pc_o=0x8000_0000, instr_o=0x13, exception_o=0; next request to 0x8000_0004.
- stall_i=1 for 5 cycles while in HOLD → pc_o, instr_o, valid_o unchanged for all 5 cycles. When stall_i drops, valid_o falls the next cycle and imem_addr=0x8000_0004.
- Redirect to 0x8000_0100 in WAIT, rvalid 3 cycles later with 0xDEADBEEF → that data is never presented; next imem_addr=0x8000_0100.
- Redirect to 0x8000_0102 → no imem_req; valid_o=1, pc_o=0x8000_0102, exception_o=16'h0001, instr_o=0.
- Response with imem_err=1 at pc 0x8000_0008 → instr_o=0, exception_o=16'h0002, pc_o=0x8000_0008.
- redirect_valid coincident with imem_rvalid in WAIT, and redirect during HOLD with stall_i=1 → response dropped / valid_o cleared; the next request goes to redirect_pc with no DROP wait.
